// File: rtl/uart_rx_frame_ctrl_if.sv
// uart_rx_frame_ctrl_if: serial line, frame configuration and received-frame outputs of the UART RX controller
interface uart_rx_frame_ctrl_if #(
  parameter int DATA_W_MAX = 9,
  parameter int PRESC_W    = 6
);
  logic                  rx_in;
  logic [PRESC_W-1:0]    prescale;
  logic [3:0]            data_len;
  logic                  par_en;
  logic                  par_type;
  logic                  stop2;
  logic [DATA_W_MAX-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  strt_glitch;
  logic                  break_det;
  logic                  busy;
  modport master (
    output rx_in, prescale, data_len, par_en, par_type, stop2,
    input  p_data, data_valid, par_err, stp_err, strt_glitch, break_det, busy
  );
  modport slave (
    input  rx_in, prescale, data_len, par_en, par_type, stop2,
    output p_data, data_valid, par_err, stp_err, strt_glitch, break_det, busy
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: oversampling UART receiver with runtime frame format, majority sampling and error/break detection
module uart_rx_frame_ctrl #(
  parameter int DATA_W_MAX = 9,
  parameter int PRESC_W    = 6
) (
  input logic clk,
  input logic reset,
  uart_rx_frame_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE, WAIT_HI} state_t;
  state_t state_q, state_d;
  logic [PRESC_W-1:0] edge_q, edge_d, presc_q, presc_d, presc_in, half;
  logic [3:0] bit_q, bit_d, len_q, len_d, len_in;
  logic par_en_q, par_en_d, par_type_q, par_type_d, stop2_q, stop2_d;
  logic [DATA_W_MAX-1:0] shift_q, shift_d, p_data_q, p_data_d;
  logic s0_q, s0_d, s1_q, s1_d, s2_q, s2_d, par_bit_q, par_bit_d;
  logic s2, bit_v, last, frame_zero, go, cap;
  assign presc_in = bus.prescale < PRESC_W'(4) ? PRESC_W'(4) : {bus.prescale[PRESC_W-1:1], 1'b0};
  assign len_in = bus.data_len < 4'd5 ? 4'd5 : bus.data_len > 4'(DATA_W_MAX) ? 4'(DATA_W_MAX) : bus.data_len;
  assign half = presc_q >> 1;
  assign last = edge_q == presc_q - PRESC_W'(1);
  // with P=4 the third sample coincides with the decision edge, so it is taken straight from the line
  assign s2 = edge_q == half + PRESC_W'(1) ? bus.rx_in : s2_q;
  assign bit_v = (s0_q & s1_q) | (s0_q & s2) | (s1_q & s2);
  assign frame_zero = shift_q == '0 && (!par_en_q || !par_bit_q);
  assign go = !bus.rx_in;
  assign cap = (state_q == IDLE || state_q == DONE) && go;
  assign bus.p_data = p_data_q;
  assign bus.busy = state_q != IDLE;
  assign bus.data_valid = state_q == DONE;
  always_comb begin
    state_d = state_q;
    edge_d = last ? '0 : edge_q + PRESC_W'(1);
    bit_d = bit_q;
    presc_d = presc_q;
    len_d = len_q;
    par_en_d = par_en_q;
    par_type_d = par_type_q;
    stop2_d = stop2_q;
    shift_d = shift_q;
    p_data_d = p_data_q;
    par_bit_d = par_bit_q;
    s0_d = edge_q == half - PRESC_W'(1) ? bus.rx_in : s0_q;
    s1_d = edge_q == half ? bus.rx_in : s1_q;
    s2_d = s2;
    bus.par_err = 1'b0;
    bus.stp_err = 1'b0;
    bus.strt_glitch = 1'b0;
    bus.break_det = 1'b0;
    case (state_q)
      IDLE: begin
        edge_d = '0;
        state_d = go ? START : IDLE;
      end
      START: if (last) begin
        bus.strt_glitch = bit_v;
        state_d = bit_v ? IDLE : DATA;
        bit_d = '0;
      end
      DATA: if (last) begin
        shift_d[bit_q] = bit_v;
        bit_d = bit_q == len_q - 4'd1 ? 4'd0 : bit_q + 4'd1;
        state_d = bit_q != len_q - 4'd1 ? DATA : par_en_q ? PARITY : STOP;
      end
      PARITY: if (last) begin
        par_bit_d = bit_v;
        bus.par_err = bit_v != (^shift_q ^ par_type_q);
        state_d = bus.par_err ? WAIT_HI : STOP;
      end
      STOP: if (last) begin
        bus.break_det = !bit_v && frame_zero;
        bus.stp_err = !bit_v && !frame_zero;
        bit_d = 4'd1;
        state_d = !bit_v ? WAIT_HI : (stop2_q && bit_q == 4'd0) ? STOP : DONE;
        p_data_d = state_d == DONE ? shift_q : p_data_q;
      end
      // the DONE cycle already spans the first line cycle of a back-to-back start bit
      DONE: begin
        edge_d = go ? PRESC_W'(1) : '0;
        state_d = go ? START : IDLE;
      end
      WAIT_HI: begin
        edge_d = '0;
        state_d = bus.rx_in ? IDLE : WAIT_HI;
      end
      default: state_d = IDLE;
    endcase
    if (cap) begin
      presc_d = presc_in;
      len_d = len_in;
      par_en_d = bus.par_en;
      par_type_d = bus.par_type;
      stop2_d = bus.stop2;
      shift_d = '0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      edge_q <= '0;
      bit_q <= '0;
      presc_q <= '0;
      len_q <= '0;
      par_en_q <= 1'b0;
      par_type_q <= 1'b0;
      stop2_q <= 1'b0;
      shift_q <= '0;
      p_data_q <= '0;
      par_bit_q <= 1'b0;
      s0_q <= 1'b0;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q <= edge_d;
      bit_q <= bit_d;
      presc_q <= presc_d;
      len_q <= len_d;
      par_en_q <= par_en_d;
      par_type_q <= par_type_d;
      stop2_q <= stop2_d;
      shift_q <= shift_d;
      p_data_q <= p_data_d;
      par_bit_q <= par_bit_d;
      s0_q <= s0_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed and randomized line waveforms checked cycle by cycle against a frame-level decoder
module tb_uart_rx_frame_ctrl;
  localparam int MAXL = 2048;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  uart_rx_frame_ctrl_if #(.DATA_W_MAX(9), .PRESC_W(6)) bus ();
  uart_rx_frame_ctrl #(.DATA_W_MAX(9), .PRESC_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));
  int vectors = 0, errors = 0;
  bit line [MAXL];
  int len;
  logic [4:0] ev_a [MAXL];
  bit busy_a [MAXL];
  bit pdset [MAXL];
  logic [8:0] pdval [MAXL];
  logic [31:0] obs_a [MAXL];
  int c_p, c_n, p_eff, n_eff;
  bit c_pe, c_pt, c_s2;
  int dvq [$], sgq [$], bdq [$];
  int cnt_pe, cnt_se;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] obs();
    return {17'b0, bus.busy, bus.data_valid, bus.par_err, bus.stp_err, bus.strt_glitch, bus.break_det, bus.p_data};
  endfunction
  function automatic int first(int q [$]);
    return q.size() > 0 ? q[0] : -1000;
  endfunction
  function automatic void set_cfg(int p, int n, bit pe, bit pt, bit s2);
    c_p = p; c_n = n; c_pe = pe; c_pt = pt; c_s2 = s2;
    p_eff = p < 4 ? 4 : (p & ~1);
    n_eff = n < 5 ? 5 : (n > 9 ? 9 : n);
    len = 0;
  endfunction
  function automatic void add(bit v, int n);
    for (int i = 0; i < n; i++) if (len < MAXL) begin line[len] = v; len++; end
  endfunction
  function automatic void add_frame(int data, bit flip_par, int bad_stop, int noise_bit);
    int base = len;
    logic [8:0] d9 = 9'(data);
    add(1'b0, p_eff);
    for (int k = 0; k < n_eff; k++) add(d9[k], p_eff);
    if (c_pe) add((^d9) ^ c_pt ^ flip_par, p_eff);
    for (int s = 0; s <= int'(c_s2); s++) add(s != bad_stop, p_eff);
    if (noise_bit >= 0 && base + p_eff * (1 + noise_bit) + p_eff / 2 + 1 < MAXL)
      line[base + p_eff * (1 + noise_bit) + p_eff / 2 + 1] ^= 1'b1;
  endfunction
  function automatic bit maj(int s);
    int ones = 0;
    for (int i = 0; i < 3; i++) ones += (s + p_eff / 2 - 1 + i < len) ? int'(line[s + p_eff / 2 - 1 + i]) : 1;
    return ones >= 2;
  endfunction
  function automatic void mark(int a, int b);
    for (int c = a; c <= b; c++) if (c < MAXL) busy_a[c] = 1'b1;
  endfunction
  function automatic void put(int c, int code);
    if (c < MAXL) ev_a[c][code] = 1'b1;
  endfunction
  // Frame-level decoder: each bit is the majority of three line samples around its centre
  function automatic void model();
    int t = 0, start, d, b, w, data, dd;
    bit more, fail, pb, v;
    logic [8:0] cur = '0;
    for (int c = 0; c < MAXL; c++) begin ev_a[c] = '0; busy_a[c] = 1'b0; pdset[c] = 1'b0; pdval[c] = '0; end
    while (t < len) begin
      if (line[t]) begin t++; continue; end
      start = t + 1;
      more = 1'b1;
      while (more) begin
        more = 1'b0;
        if (maj(start)) begin
          d = start + p_eff - 1; put(d, 1); mark(start, d); t = d + 1;
        end else begin
          data = 0;
          for (int k = 1; k <= n_eff; k++) if (maj(start + p_eff * k)) data |= 1 << (k - 1);
          b = n_eff + 1; pb = 1'b0; fail = 1'b0; d = 0;
          if (c_pe) begin
            pb = maj(start + p_eff * b); d = start + p_eff * b + p_eff - 1;
            if (pb != ((^data) ^ c_pt)) begin put(d, 3); fail = 1'b1; end
            b++;
          end
          for (int s = 0; !fail && s <= int'(c_s2); s++) begin
            v = maj(start + p_eff * b); d = start + p_eff * b + p_eff - 1;
            if (!v) begin put(d, (data == 0 && (!c_pe || !pb)) ? 0 : 2); fail = 1'b1; end
            b++;
          end
          if (fail) begin
            mark(start, d); w = d + 1;
            while (w < len && !line[w]) w++;
            mark(d + 1, w); t = w + 1;
          end else begin
            dd = start + p_eff * b;
            mark(start, dd); put(dd, 4);
            if (dd < MAXL) begin pdset[dd] = 1'b1; pdval[dd] = 9'(data); end
            if (dd < len && !line[dd]) begin start = dd; more = 1'b1; end else t = dd + 1;
          end
        end
      end
    end
    for (int c = 0; c < MAXL; c++) begin
      if (pdset[c]) cur = pdval[c];
      pdval[c] = cur;
    end
  endfunction
  task automatic drive_cfg(bit real_cfg);
    bus.prescale = real_cfg ? 6'(c_p) : 6'($urandom);
    bus.data_len = real_cfg ? 4'(c_n) : 4'($urandom);
    bus.par_en = real_cfg ? c_pe : 1'($urandom);
    bus.par_type = real_cfg ? c_pt : 1'($urandom);
    bus.stop2 = real_cfg ? c_s2 : 1'($urandom);
  endtask
  task automatic run(string name, int stop_at);
    logic [31:0] o;
    model();
    dvq.delete(); sgq.delete(); bdq.delete(); cnt_pe = 0; cnt_se = 0;
    reset = 1'b1; bus.rx_in = 1'b1; drive_cfg(1'b1);
    @(negedge clk);
    check({name, " reset"}, obs(), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    for (int c = 0; c < len; c++) begin
      bus.rx_in = line[c];
      drive_cfg(!busy_a[c] || ev_a[c][4]);
      @(negedge clk);
      o = obs();
      obs_a[c] = o;
      check($sformatf("%s c%0d", name, c), o, {17'b0, busy_a[c], ev_a[c], pdval[c]});
      if (bus.data_valid) dvq.push_back(c);
      if (bus.strt_glitch) sgq.push_back(c);
      if (bus.break_det) bdq.push_back(c);
      if (bus.par_err) cnt_pe++;
      if (bus.stp_err) cnt_se++;
      if (c == stop_at) begin
        #2 reset = 1'b1;
        #1 check({name, " async_rst"}, obs(), 32'h0);
        return;
      end
      @(posedge clk); #1;
    end
  endtask
  initial begin
    int i, kind, gap;
    bus.rx_in = 1'b1;
    drive_cfg(1'b1);
    set_cfg(8, 8, 0, 0, 0); add(1, 5); add_frame('hA5, 0, -1, -1); add(1, 20);
    run("t1", -1);
    check("t1_lat", first(dvq) - 5, 81);
    i = first(dvq);
    check("t1_pdata", i >= 0 ? obs_a[i][8:0] : 9'h1FF, 9'h0A5);
    set_cfg(16, 7, 1, 0, 1); add(1, 5); add_frame('h55, 0, -1, -1); add(1, 20); add_frame('h55, 1, -1, -1); add(1, 40);
    run("t2", -1);
    check("t2_dv", dvq.size(), 1);
    check("t2_par", cnt_pe, 1);
    set_cfg(8, 8, 0, 0, 0); add(1, 5); add(0, 3); add(1, 20);
    run("t3", -1);
    check("t3_glitch", first(sgq) - 5, 8);
    check("t3_busy8", obs_a[13][14], 1);
    check("t3_busy9", obs_a[14][14], 0);
    set_cfg(8, 8, 0, 0, 0); add(1, 5); add(0, 200); add(1, 30);
    run("t4", -1);
    check("t4_brk", bdq.size(), 1);
    check("t4_stp", cnt_se, 0);
    set_cfg(8, 8, 0, 0, 0); add(1, 5); add_frame('h3C, 0, -1, -1); add_frame('hC3, 0, -1, -1); add(1, 20);
    run("t5", -1);
    check("t5_gap", dvq.size() == 2 ? dvq[1] - dvq[0] : -1, 80);
    set_cfg(8, 8, 0, 0, 0); add(1, 5); add_frame('h5A, 0, -1, -1); add(1, 10); add_frame('h66, 0, -1, -1); add(1, 20);
    run("t6a", 5 + 80 + 1 + 10 + 1 + 42);
    set_cfg(8, 8, 0, 0, 0); add(1, 5); add_frame('h81, 0, -1, -1); add(1, 20);
    run("t6b", -1);
    i = first(dvq);
    check("t6_pdata", i >= 0 ? obs_a[i][8:0] : 9'h1FF, 9'h081);
    for (int s = 0; s < 25; s++) begin
      set_cfg(2 * $urandom_range(1, 8), $urandom_range(0, 15), 1'($urandom), 1'($urandom), 1'($urandom));
      add(1, $urandom_range(1, 10));
      for (int f = 0; f < 3; f++) begin
        kind = $urandom_range(0, 9);
        case (kind)
          5: add_frame($urandom, 1, -1, -1);
          6: add_frame($urandom, 0, $urandom_range(0, int'(c_s2)), -1);
          7: add(0, $urandom_range(1, p_eff / 2 - 1));
          8: add(0, p_eff * (n_eff + 4) + $urandom_range(0, 2 * p_eff));
          default: add_frame($urandom & ((1 << n_eff) - 1), 0, -1, kind == 4 ? $urandom_range(0, n_eff - 1) : -1);
        endcase
        gap = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 3 * p_eff);
        add(1, gap);
      end
      add(1, 16);
      run($sformatf("rnd%0d", s), -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
